// File: rtl/serial_adder_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder_ctrl_if
// Description : Operand/result handshake bundle for the bit-serial adder.
//               The slave modport belongs to the adder. The master modport
//               belongs to the block that supplies operands and takes results.
// Revision    : 1.0 - initial release
// ============================================================================
interface serial_adder_ctrl_if #(
  parameter int N = 8
);
  // Upstream side: operands in.
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         cin;
  // Downstream side: result out.
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] sum;
  logic         cout;
  logic         ovf;

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );
endinterface
`default_nettype wire

// File: rtl/serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder_ctrl (with leaf adder_1bit)
// Description : Bit-serial N-bit adder. It latches A, B and carry-in, then
//               runs one full-adder cell LSB first, one bit per cycle. It
//               presents sum, carry-out and signed overflow through
//               valid/ready handshakes on the input and output sides.
// Revision    : 1.0 - initial release
// ============================================================================

// Single-bit full adder cell.
module adder_1bit (
  input  logic A,
  input  logic B,
  input  logic Ci,
  output logic Co,
  output logic S
);
  assign S  = A ^ B ^ Ci;
  assign Co = (A & B) | (A & Ci) | (B & Ci);
endmodule

module serial_adder_ctrl #(
  parameter int N = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_adder_ctrl_if.slave   bus
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state;
  logic [N-1:0]  a_sh;
  logic [N-1:0]  b_sh;
  logic [N-1:0]  acc;
  logic          carry;
  logic          ovf_bit;
  logic [CW-1:0] cnt;
  logic          s_bit;
  logic          co_bit;

  // The adder cell always looks at the current LSBs and the registered carry.
  adder_1bit u_adder (
    .A  (a_sh[0]),
    .B  (b_sh[0]),
    .Ci (carry),
    .Co (co_bit),
    .S  (s_bit)
  );

  // Sequencer: accept operands, shift one bit per cycle, hold result until taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      a_sh    <= '0;
      b_sh    <= '0;
      acc     <= '0;
      carry   <= 1'b0;
      cnt     <= '0;
      ovf_bit <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            a_sh  <= bus.a;
            b_sh  <= bus.b;
            carry <= bus.cin;
            acc   <= '0;
            cnt   <= '0;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          acc   <= {s_bit, acc[N-1:1]};
          carry <= co_bit;
          cnt   <= cnt + CW'(1);
          if (cnt == CNT_LAST) begin
            // On this cycle, carry holds the carry into the MSB.
            ovf_bit <= carry ^ co_bit;
            state   <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Outputs are decoded from state or taken straight from registers. in_ready
  // is also gated by rst so that no operand is offered during reset.
  assign bus.in_ready  = (state == S_IDLE) && !rst;
  assign bus.out_valid = (state == S_DONE);
  assign bus.sum       = acc;
  assign bus.cout      = carry;
  assign bus.ovf       = ovf_bit;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_adder_ctrl
// Description : Self-checking bench for serial_adder_ctrl. Instances are
//               built at N=8 and at N=2. Results are checked against a+b+cin
//               worked out with plain integer arithmetic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_adder_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  serial_adder_ctrl_if #(.N(8)) bus8 ();
  serial_adder_ctrl_if #(.N(2)) bus2 ();

  serial_adder_ctrl #(.N(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));
  serial_adder_ctrl #(.N(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

  int compared   = 0;
  int mismatched = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: unsigned sum/carry and two's-complement range check.
  task automatic model(input int n, input int a, input int b, input int ci,
                       output int s, output int co, output int ov);
    int u, sa, sb, ss, lim;
    lim = 1 << n;
    u   = a + b + ci;
    s   = u % lim;
    co  = (u >= lim) ? 1 : 0;
    sa  = (a >= lim / 2) ? a - lim : a;
    sb  = (b >= lim / 2) ? b - lim : b;
    ss  = sa + sb + ci;
    ov  = (ss >= lim / 2 || ss < -(lim / 2)) ? 1 : 0;
  endtask

  // Present one operand set and wait for the result. This leaves DUT8 in DONE.
  task automatic issue8(input int a, input int b, input int ci, input string tag);
    int n, lat, es, ec, eo;
    n = 0;
    while (!bus8.in_ready && n < 20) begin step(); n++; end
    chk({tag, "_in_ready"}, 32'(bus8.in_ready), 32'd1);
    bus8.a = 8'(a); bus8.b = 8'(b); bus8.cin = ci[0]; bus8.in_valid = 1'b1;
    step();
    bus8.in_valid = 1'b0;
    lat = 0;
    while (!bus8.out_valid && lat < 14) begin step(); lat++; end
    chk({tag, "_latency"}, 32'(lat), 32'd8);
    model(8, a, b, ci, es, ec, eo);
    chk({tag, "_sum"},  32'(bus8.sum),  32'(es));
    chk({tag, "_cout"}, 32'(bus8.cout), 32'(ec));
    chk({tag, "_ovf"},  32'(bus8.ovf),  32'(eo));
  endtask

  task automatic retire8(input string tag);
    bus8.out_ready = 1'b1;
    step();
    bus8.out_ready = 1'b0;
    chk({tag, "_valid_drop"}, 32'(bus8.out_valid), 32'd0);
    chk({tag, "_idle_ready"}, 32'(bus8.in_ready), 32'd1);
  endtask

  task automatic add2(input int a, input int b, input int ci);
    int n, es, ec, eo;
    n = 0;
    while (!bus2.in_ready && n < 10) begin step(); n++; end
    bus2.a = 2'(a); bus2.b = 2'(b); bus2.cin = ci[0]; bus2.in_valid = 1'b1;
    step();
    bus2.in_valid = 1'b0;
    n = 0;
    while (!bus2.out_valid && n < 8) begin step(); n++; end
    model(2, a, b, ci, es, ec, eo);
    chk($sformatf("n2_%0d_%0d_%0d_sum_cout", a, b, ci),
        32'({bus2.cout, bus2.sum}), 32'({ec[0], es[1:0]}));
    chk($sformatf("n2_%0d_%0d_%0d_ovf", a, b, ci), 32'(bus2.ovf), 32'(eo));
    bus2.out_ready = 1'b1;
    step();
    bus2.out_ready = 1'b0;
  endtask

  initial begin
    int ra[4], rb[4], rc[4];
    int exp_s[$], exp_c[$], exp_o[$];
    int sent, got, last_t, es, ec, eo;
    logic [7:0] held_sum;
    logic       held_c, held_o;

    bus8.in_valid = 1'b0; bus8.out_ready = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0;
    bus2.in_valid = 1'b0; bus2.out_ready = 1'b0; bus2.a = '0; bus2.b = '0; bus2.cin = 1'b0;

    // Reset state.
    step(); step();
    chk("rst_in_ready_low", 32'(bus8.in_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_out_valid", 32'(bus8.out_valid), 32'd0);
    chk("rst_in_ready",  32'(bus8.in_ready),  32'd1);
    chk("rst_sum",       32'(bus8.sum),       32'd0);
    chk("rst_cout_ovf",  32'({bus8.cout, bus8.ovf}), 32'd0);

    // Directed sums, including carry and overflow boundaries.
    issue8(8'h5A, 8'h33, 0, "t1");  retire8("t1");
    issue8(8'hFF, 8'h01, 0, "t2a"); retire8("t2a");
    issue8(8'h7F, 8'h00, 1, "t2b"); retire8("t2b");
    issue8(8'h80, 8'h80, 0, "t2c"); retire8("t2c");
    issue8(8'hFF, 8'hFF, 1, "t2d"); retire8("t2d");

    // Backpressure: result holds while new operands are offered.
    issue8(8'hC3, 8'h4E, 1, "t3");
    held_sum = bus8.sum; held_c = bus8.cout; held_o = bus8.ovf;
    for (int i = 0; i < 5; i++) begin
      bus8.a = 8'($urandom); bus8.b = 8'($urandom); bus8.cin = 1'($urandom);
      bus8.in_valid = i[0];
      step();
      chk($sformatf("t3_hold_sum_%0d", i), 32'(bus8.sum), 32'(held_sum));
      chk($sformatf("t3_hold_co_%0d", i), 32'({bus8.cout, bus8.ovf}), 32'({held_c, held_o}));
      chk($sformatf("t3_in_ready_%0d", i), 32'(bus8.in_ready), 32'd0);
      chk($sformatf("t3_valid_%0d", i), 32'(bus8.out_valid), 32'd1);
    end
    bus8.in_valid = 1'b0;
    retire8("t3");
    chk("t3_no_stray_run", 32'(bus8.sum), 32'(held_sum));

    // Reset in the middle of a run, at cnt == 3.
    bus8.a = 8'hFF; bus8.b = 8'hFF; bus8.cin = 1'b1; bus8.in_valid = 1'b1;
    step();
    bus8.in_valid = 1'b0;
    step(); step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("t4_out_valid", 32'(bus8.out_valid), 32'd0);
    chk("t4_in_ready",  32'(bus8.in_ready),  32'd1);
    issue8(8'h10, 8'h20, 0, "t4"); retire8("t4");

    // Random operands against the reference model.
    for (int i = 0; i < 12; i++) begin
      issue8(int'($urandom_range(255)), int'($urandom_range(255)),
             int'($urandom_range(1)), $sformatf("rnd%0d", i));
      retire8($sformatf("rnd%0d", i));
    end

    // Back-to-back: in_valid and out_ready tied high, 4 random pairs.
    for (int i = 0; i < 4; i++) begin
      ra[i] = int'($urandom_range(255)); rb[i] = int'($urandom_range(255));
      rc[i] = int'($urandom_range(1));
    end
    sent = 0; got = 0; last_t = -1;
    bus8.out_ready = 1'b1;
    bus8.a = 8'(ra[0]); bus8.b = 8'(rb[0]); bus8.cin = rc[0][0]; bus8.in_valid = 1'b1;
    for (int cyc = 0; cyc < 60 && got < 4; cyc++) begin
      if (bus8.out_valid) begin
        if (exp_s.size() > 0) begin
          chk($sformatf("t5_sum_%0d", got), 32'({bus8.cout, bus8.ovf, bus8.sum}),
              32'({exp_c[0][0], exp_o[0][0], exp_s[0][7:0]}));
          void'(exp_s.pop_front()); void'(exp_c.pop_front()); void'(exp_o.pop_front());
        end else begin
          chk("t5_unexpected_result", 32'd1, 32'd0);
        end
        if (last_t >= 0) chk($sformatf("t5_spacing_%0d", got), 32'(cyc - last_t), 32'd10);
        last_t = cyc;
        got++;
      end
      if (bus8.in_ready && bus8.in_valid) begin
        model(8, ra[sent], rb[sent], rc[sent], es, ec, eo);
        exp_s.push_back(es); exp_c.push_back(ec); exp_o.push_back(eo);
        sent++;
        step();
        if (sent < 4) begin
          bus8.a = 8'(ra[sent]); bus8.b = 8'(rb[sent]); bus8.cin = rc[sent][0];
        end else begin
          bus8.in_valid = 1'b0;
        end
      end else begin
        step();
      end
    end
    chk("t5_result_count", 32'(got), 32'd4);
    bus8.in_valid = 1'b0;
    step();
    bus8.out_ready = 1'b0;

    // Exhaustive check at N=2.
    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++)
        for (int c = 0; c < 2; c++)
          add2(a, b, c);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
